// File: rtl/fetch_queue.sv
// Instruction fetch front end: holds the PC, issues one outstanding request to instruction
// memory over req/gnt/rvalid and buffers returned {pc, instr} pairs in a small FIFO for decode.
module fetch_queue #(
    parameter int unsigned   N        = 64,
    parameter int unsigned   IW       = 32,
    parameter int unsigned   DEPTH    = 4,
    parameter logic [N-1:0]  RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          PCSrc_F,
    input  logic [N-1:0]  PCBranch_F,
    output logic          imem_req_F,
    output logic [N-1:0]  imem_addr_F,
    input  logic          imem_gnt_F,
    input  logic          imem_rvalid_F,
    input  logic [IW-1:0] imem_rdata_F,
    input  logic          enable,
    output logic          instr_valid_F,
    output logic [IW-1:0] instr_F,
    output logic [N-1:0]  instr_pc_F
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_e;

    typedef struct packed {
        logic [N-1:0]  pc;
        logic [IW-1:0] instr;
    } entry_t;

    state_e             state_q, state_d;
    logic [N-1:0]       pc_q, pc_d;
    logic [N-1:0]       req_pc_q, req_pc_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    entry_t             mem_q [DEPTH];

    logic               fire;
    logic               push;
    logic               pop;

    // A redirect suppresses the request in the same cycle so the new target is fetched next cycle.
    assign imem_req_F  = reset && (state_q == IDLE) && (count_q < CNT_W'(DEPTH)) && !PCSrc_F;
    assign imem_addr_F = pc_q;

    assign fire = imem_req_F && imem_gnt_F;
    assign push = (state_q == WAIT) && imem_rvalid_F && !PCSrc_F;
    assign pop  = enable && (count_q != '0) && !PCSrc_F;

    assign instr_valid_F = (count_q != '0);
    assign instr_F       = mem_q[rd_ptr_q].instr;
    assign instr_pc_F    = mem_q[rd_ptr_q].pc;

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        unique case (state_q)
            IDLE: begin
                if (fire) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid_F) begin
                    state_d = IDLE;
                end else if (PCSrc_F) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem_rvalid_F) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (PCSrc_F) begin
            pc_d     = PCBranch_F;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (fire) begin
                pc_d     = pc_q + N'(4);
                req_pc_d = pc_q;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is reset so the head outputs read zero out of reset; it is only a few entries.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= '{pc: req_pc_q, instr: imem_rdata_F};
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: streaming, full FIFO, redirects, grant stall, async reset, PC wrap.
module tb_fetch_queue;

    logic        clk;
    logic        reset;
    logic        PCSrc_F;
    logic [63:0] PCBranch_F;
    logic        imem_req_F;
    logic [63:0] imem_addr_F;
    logic        imem_gnt_F;
    logic        imem_rvalid_F;
    logic [31:0] imem_rdata_F;
    logic        enable;
    logic        instr_valid_F;
    logic [31:0] instr_F;
    logic [63:0] instr_pc_F;

    // Second instance only exercises PC wrap-around from a high reset PC.
    logic        b_req;
    logic [63:0] b_addr;
    logic        b_gnt;
    logic        b_rvalid;
    logic [31:0] b_rdata;
    logic        b_valid;
    logic [31:0] b_instr;
    logic [63:0] b_pc;

    int n_checks = 0;
    int n_errors = 0;

    fetch_queue #(.N(64), .IW(32), .DEPTH(4), .RESET_PC(64'h0)) dut (
        .clk           (clk),
        .reset         (reset),
        .PCSrc_F       (PCSrc_F),
        .PCBranch_F    (PCBranch_F),
        .imem_req_F    (imem_req_F),
        .imem_addr_F   (imem_addr_F),
        .imem_gnt_F    (imem_gnt_F),
        .imem_rvalid_F (imem_rvalid_F),
        .imem_rdata_F  (imem_rdata_F),
        .enable        (enable),
        .instr_valid_F (instr_valid_F),
        .instr_F       (instr_F),
        .instr_pc_F    (instr_pc_F)
    );

    fetch_queue #(.N(64), .IW(32), .DEPTH(4), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
        .clk           (clk),
        .reset         (reset),
        .PCSrc_F       (1'b0),
        .PCBranch_F    (64'h0),
        .imem_req_F    (b_req),
        .imem_addr_F   (b_addr),
        .imem_gnt_F    (b_gnt),
        .imem_rvalid_F (b_rvalid),
        .imem_rdata_F  (b_rdata),
        .enable        (1'b0),
        .instr_valid_F (b_valid),
        .instr_F       (b_instr),
        .instr_pc_F    (b_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; PCSrc_F = 1'b0; PCBranch_F = '0; imem_gnt_F = 1'b0;
        imem_rvalid_F = 1'b0; imem_rdata_F = '0; enable = 1'b0;
        b_gnt = 1'b0; b_rvalid = 1'b0; b_rdata = '0;

        // Reset state
        #2;
        check("rst_req",   imem_req_F,    0);
        check("rst_valid", instr_valid_F, 0);
        check("rst_instr", instr_F,       0);
        check("rst_pc",    instr_pc_F,    0);
        check("rst_addr",  imem_addr_F,   0);
        #1 reset = 1'b1;
        next();

        // Stream: 1-cycle latency, enable=1, one request every 2 cycles
        enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            imem_gnt_F = 1'b1; imem_rvalid_F = 1'b0;
            #1;
            check("stream_req",   imem_req_F,    1);
            check("stream_addr",  imem_addr_F,   64'(4 * k));
            check("stream_valid", instr_valid_F, (k > 0) ? 64'd1 : 64'd0);
            if (k > 0) begin
                check("stream_hpc",   instr_pc_F, 64'(4 * (k - 1)));
                check("stream_instr", instr_F,    64'(32'hA000_0000 + 32'(4 * (k - 1))));
            end
            next();
            imem_rvalid_F = 1'b1; imem_rdata_F = 32'hA000_0000 + 32'(4 * k);
            #1;
            check("stream_req_wait", imem_req_F, 0);
            next();
        end
        imem_rvalid_F = 1'b0; imem_gnt_F = 1'b0;
        #1;
        check("stream_last_valid", instr_valid_F, 1);
        check("stream_last_hpc",   instr_pc_F,    64'h8);
        check("stream_last_instr", instr_F,       64'hA000_0008);
        enable = 1'b0;
        reset = 1'b0;
        #1 reset = 1'b1;
        next();

        // Full: fill 4 entries with enable=0
        for (int k = 0; k < 4; k++) begin
            imem_gnt_F = 1'b1; imem_rvalid_F = 1'b0;
            #1;
            check("fill_req",  imem_req_F,  1);
            check("fill_addr", imem_addr_F, 64'(4 * k));
            next();
            imem_rvalid_F = 1'b1; imem_rdata_F = 32'hA000_0000 + 32'(4 * k);
            #1;
            check("fill_req_wait", imem_req_F, 0);
            next();
        end
        imem_rvalid_F = 1'b0; imem_gnt_F = 1'b1;
        #1;
        check("full_req",   imem_req_F,    0);
        check("full_addr",  imem_addr_F,   64'h10);
        check("full_valid", instr_valid_F, 1);
        check("full_hpc",   instr_pc_F,    64'h0);
        check("full_instr", instr_F,       64'hA000_0000);
        enable = 1'b1;
        next();
        enable = 1'b0;
        #1;
        check("after_pop_req",   imem_req_F,  1);
        check("after_pop_addr",  imem_addr_F, 64'h10);
        check("after_pop_hpc",   instr_pc_F,  64'h4);
        check("after_pop_instr", instr_F,     64'hA000_0004);
        next();

        // Redirect coincident with rvalid in WAIT, two entries held, enable=1
        imem_gnt_F = 1'b0; enable = 1'b1;
        #1;
        check("wait_req", imem_req_F, 0);
        check("wait_hpc", instr_pc_F, 64'h4);
        next();
        PCSrc_F = 1'b1; PCBranch_F = 64'h200; imem_rvalid_F = 1'b1; imem_rdata_F = 32'hDEAD_BEEF;
        #1;
        check("coinc_req",   imem_req_F,    0);
        check("coinc_valid", instr_valid_F, 1);
        check("coinc_hpc",   instr_pc_F,    64'h8);
        next();
        PCSrc_F = 1'b0; imem_rvalid_F = 1'b0; enable = 1'b0; imem_gnt_F = 1'b0;

        // Grant stall at the redirect target
        for (int s = 0; s < 3; s++) begin
            #1;
            check("coinc_flushed", instr_valid_F, 0);
            check("stall_req",     imem_req_F,    1);
            check("stall_addr",    imem_addr_F,   64'h200);
            next();
        end
        imem_gnt_F = 1'b1;
        #1;
        check("stall_grant_addr", imem_addr_F, 64'h200);
        next();

        // Redirect in WAIT, response arrives two cycles later
        imem_gnt_F = 1'b0; PCSrc_F = 1'b1; PCBranch_F = 64'h100;
        #1;
        check("redir_req", imem_req_F, 0);
        next();
        PCSrc_F = 1'b0;
        #1;
        check("drop_req",  imem_req_F,  0);
        check("drop_addr", imem_addr_F, 64'h100);
        next();
        imem_rvalid_F = 1'b1; imem_rdata_F = 32'hDEAD_BEEF;
        #1;
        check("drop_rvalid_req", imem_req_F, 0);
        next();
        imem_rvalid_F = 1'b0; imem_gnt_F = 1'b1;
        #1;
        check("drop_valid",    instr_valid_F, 0);
        check("drop_next_req", imem_req_F,    1);
        check("drop_next_addr", imem_addr_F,  64'h100);
        next();
        imem_gnt_F = 1'b0; imem_rvalid_F = 1'b1; imem_rdata_F = 32'h1111_1111;
        #1;
        check("fetch100_wait", imem_req_F, 0);
        next();
        imem_rvalid_F = 1'b0; imem_gnt_F = 1'b1;
        #1;
        check("fetch100_hpc",   instr_pc_F,  64'h100);
        check("fetch100_instr", instr_F,     64'h1111_1111);
        check("fetch100_addr",  imem_addr_F, 64'h104);
        next();

        // Async reset mid-WAIT, then a late rvalid is ignored
        imem_gnt_F = 1'b0;
        #1;
        check("prerst_valid", instr_valid_F, 1);
        check("prerst_req",   imem_req_F,    0);
        #1 reset = 1'b0;
        #1;
        check("arst_valid", instr_valid_F, 0);
        check("arst_instr", instr_F,       0);
        check("arst_hpc",   instr_pc_F,    0);
        check("arst_req",   imem_req_F,    0);
        check("arst_addr",  imem_addr_F,   0);
        reset = 1'b1;
        imem_rvalid_F = 1'b1; imem_rdata_F = 32'h0000_0BAD; enable = 1'b1;
        next();
        imem_rvalid_F = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1;
            check("late_rvalid_valid", instr_valid_F, 0);
            check("gstall_req",        imem_req_F,    1);
            check("gstall_addr",       imem_addr_F,   64'h0);
            next();
        end
        imem_gnt_F = 1'b1;
        #1;
        check("gstall_grant_req", imem_req_F, 1);
        next();
        imem_gnt_F = 1'b0;
        #1;
        check("gstall_after_req",  imem_req_F,  0);
        check("gstall_after_addr", imem_addr_F, 64'h4);

        // PC wrap from RESET_PC = 2^64-4
        check("wrap_req0",  b_req,  1);
        check("wrap_addr0", b_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        b_gnt = 1'b1;
        next();
        b_gnt = 1'b0; b_rvalid = 1'b1; b_rdata = 32'hCAFE_0000;
        #1;
        check("wrap_wait_req", b_req,  0);
        check("wrap_addr1",    b_addr, 64'h0);
        next();
        b_rvalid = 1'b0;
        #1;
        check("wrap_req1",  b_req,   1);
        check("wrap_addr2", b_addr,  64'h0);
        check("wrap_valid", b_valid, 1);
        check("wrap_hpc",   b_pc,    64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_instr", b_instr, 64'hCAFE_0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
